// File: rtl/lut_layer_sequencer.sv
// ---------------------------------------------------------------------------
// lut_layer_sequencer
//
// Evaluates one layer of a LUT-based network by time-multiplexing a single
// 6-input LUT evaluator across NEURONS neurons, one neuron per clock.
// Each neuron owns a 64-entry truth table and six input selects that pick
// bits of the captured layer input vector to form the LUT address.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   input vector handshake (ready only while idle)
//   in_data          layer input vector, IN_WIDTH bits
//   out_valid/ready  result handshake
//   out_data         one result bit per neuron
//   cfg_we           write strobe for one neuron's configuration
//   cfg_addr         neuron index to write
//   cfg_table        truth table, bit a = output for LUT address a
//   cfg_sel          six select fields, field k drives LUT address bit k
//   cfg_err          one-cycle pulse when a configuration write is rejected
// ---------------------------------------------------------------------------
module lut_layer_sequencer #(
  parameter int IN_WIDTH = 64,
  parameter int NEURONS  = 32,
  localparam int SELW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1,
  localparam int NIDW = (NEURONS  > 1) ? $clog2(NEURONS)  : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NEURONS-1:0]    out_data,
  input  logic                  cfg_we,
  input  logic [NIDW-1:0]       cfg_addr,
  input  logic [63:0]           cfg_table,
  input  logic [6*SELW-1:0]     cfg_sel,
  output logic                  cfg_err
);

  localparam int FANIN = 6;

  // Comparison constants are one bit wider than the field they are compared
  // against so that a power-of-two count does not truncate to zero.
  localparam logic [NIDW:0]   NEURONS_W  = (NIDW + 1)'(NEURONS);
  localparam logic [SELW:0]   IN_WIDTH_W = (SELW + 1)'(IN_WIDTH);
  localparam logic [NIDW-1:0] LAST_N     = NIDW'(NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NIDW-1:0]      cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]  vec_q, vec_d;
  logic [NEURONS-1:0]   result_q, result_d;
  logic                 out_valid_q, out_valid_d;
  logic                 cfg_err_q, cfg_err_d;

  // Configuration memories, deliberately left out of reset.
  logic [63:0]          table_mem [NEURONS];
  logic [FANIN*SELW-1:0] sel_mem  [NEURONS];

  logic                 accept;
  logic                 addr_ok;
  logic                 cfg_wr;
  logic                 cfg_rej;
  logic [FANIN*SELW-1:0] sel_cur;
  logic [SELW-1:0]      field;
  logic [FANIN-1:0]     lut_addr;
  logic                 lut_bit;

  // -------------------------------------------------------------------------
  // Handshake and configuration qualification
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    accept  = in_valid && in_ready;
    addr_ok = ({1'b0, cfg_addr} < NEURONS_W);
    cfg_wr  = cfg_we && !rst && (state_q == IDLE) && addr_ok;
    cfg_rej = cfg_we && !rst && !((state_q == IDLE) && addr_ok);
  end

  // -------------------------------------------------------------------------
  // LUT evaluator for the neuron selected by the counter
  // -------------------------------------------------------------------------
  always_comb begin
    sel_cur  = sel_mem[cnt_q];
    lut_addr = '0;
    field    = '0;
    for (int unsigned k = 0; k < FANIN; k++) begin
      field = sel_cur[k*SELW +: SELW];
      // Select values beyond the vector width fall back to input bit 0.
      if ({1'b0, field} < IN_WIDTH_W) begin
        lut_addr[k] = vec_q[field];
      end else begin
        lut_addr[k] = vec_q[0];
      end
    end
    lut_bit = table_mem[cnt_q][lut_addr];
  end

  // -------------------------------------------------------------------------
  // Sequencer next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_rej;

    case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d   = in_data;
          cnt_d   = '0;
          state_d = EVAL;
        end
      end

      EVAL: begin
        result_d[cnt_q] = lut_bit;
        if (cnt_q == LAST_N) begin
          // Counter parks on the last neuron rather than wrapping.
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + NIDW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Configuration memories
  // -------------------------------------------------------------------------
  // A write coincident with an accepted vector lands on the accepting edge,
  // before the first evaluation cycle reads it.
  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      table_mem[cfg_addr] <= cfg_table;
      sel_mem[cfg_addr]   <= cfg_sel;
    end
  end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lut_layer_sequencer
//
// Directed bench for lut_layer_sequencer with IN_WIDTH=8, NEURONS=4.
// A second instance with NEURONS=3 exercises rejection of an out-of-range
// neuron index, which a 2-bit index cannot express for four neurons.
// ---------------------------------------------------------------------------
module tb_lut_layer_sequencer;

  localparam logic [17:0] SEL_ID = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZERO   = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [63:0] cfg_table = '0;
  logic [17:0] cfg_sel = '0;
  logic        cfg_err;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [2:0]  b_out_data;
  logic        b_cfg_we = 1'b0;
  logic [1:0]  b_cfg_addr = '0;
  logic [63:0] b_cfg_table = '0;
  logic [17:0] b_cfg_sel = '0;
  logic        b_cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lut_layer_sequencer #(.IN_WIDTH(8), .NEURONS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_table(cfg_table),
    .cfg_sel(cfg_sel), .cfg_err(cfg_err)
  );

  lut_layer_sequencer #(.IN_WIDTH(8), .NEURONS(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_table(b_cfg_table),
    .cfg_sel(b_cfg_sel), .cfg_err(b_cfg_err)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [63:0] t, input logic [17:0] s);
    cfg_we = 1'b1; cfg_addr = a; cfg_table = t; cfg_sel = s;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input logic [63:0] t0, input logic [63:0] t1,
                         input logic [63:0] t2, input logic [63:0] t3);
    cfg_write(2'd0, t0, SEL_ID);
    cfg_write(2'd1, t1, SEL_ID);
    cfg_write(2'd2, t2, SEL_ID);
    cfg_write(2'd3, t3, SEL_ID);
  endtask

  // Offer a vector, change in_data after capture, wait (bounded) for the
  // result, then complete the output handshake. lat counts edges after the
  // accepting edge until out_valid is seen; 99 marks a timeout.
  task automatic run_vec(input logic [7:0] d, input logic [7:0] d_after,
                         output logic [3:0] res, output int lat);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = d_after;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = 99;
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset_out_data got %b want 0000", out_data); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_all_ones();
    for (int n = 0; n < 4; n++) begin
      cfg_write(2'(n), 64'h0000_0000_0000_0001, SEL_ID);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_ok_err n=%0d got %b want 0", n, cfg_err); end
    end
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early c=%0d got %b want 0", c, out_valid); end
    end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_t4 got %b want 1", out_valid); end
    checks++; if (out_data !== 4'b1111) begin errors++; $display("FAIL all_ones_data got %b want 1111", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handshake_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handshake_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 4'b1111) begin errors++; $display("FAIL retain_data got %b want 1111", out_data); end
  endtask

  task automatic test_single_neuron();
    logic [3:0] res;
    int lat;
    cfg_all(ZERO, ZERO, 64'h8000_0000_0000_0000, ZERO);
    run_vec(8'h3F, 8'h00, res, lat);
    checks++; if (res !== 4'b0100) begin errors++; $display("FAIL single_3F got %b want 0100", res); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_lat got %0d want 4", lat); end
    run_vec(8'h3E, 8'h3F, res, lat);
    checks++; if (res !== 4'b0000) begin errors++; $display("FAIL single_3E got %b want 0000", res); end
    run_vec(8'hFF, 8'h00, res, lat);
    checks++; if (res !== 4'b0100) begin errors++; $display("FAIL single_FF got %b want 0100", res); end
  endtask

  task automatic test_select();
    logic [3:0] res;
    int lat;
    cfg_all(ZERO, ZERO, ZERO, ZERO);
    // Neuron 3: address bit 1 from input bit 6, all others from input bit 7.
    cfg_write(2'd3, 64'h0000_0000_0000_0004, {3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd7});
    run_vec(8'h40, 8'hC0, res, lat);
    checks++; if (res !== 4'b1000) begin errors++; $display("FAIL select_40 got %b want 1000", res); end
    run_vec(8'hC0, 8'h40, res, lat);
    checks++; if (res !== 4'b0000) begin errors++; $display("FAIL select_C0 got %b want 0000", res); end
  endtask

  task automatic test_stall();
    int lat;
    cfg_all(ONES, ZERO, ONES, ZERO);
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_reach_done got %b want 1", out_valid); end
    in_valid = 1'b1; in_data = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got %b want 1", c, out_valid); end
      checks++; if (out_data !== 4'b0101) begin errors++; $display("FAIL stall_data c=%0d got %b want 0101", c, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 4'b0101) begin errors++; $display("FAIL stall_release_data got %b want 0101", out_data); end
  endtask

  task automatic test_cfg_during_eval();
    logic [3:0] res;
    int lat;
    cfg_all(ZERO, ONES, ZERO, ZERO);
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_table = ZERO; cfg_sel = SEL_ID;
    tick();
    cfg_we = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL eval_cfg_err got %b want 1", cfg_err); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL eval_cfg_err_pulse got %b want 0", cfg_err); end
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (out_data !== 4'b0010) begin errors++; $display("FAIL eval_cfg_result got %b want 0010", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_vec(8'h00, 8'h00, res, lat);
    checks++; if (res !== 4'b0010) begin errors++; $display("FAIL eval_cfg_unchanged got %b want 0010", res); end
  endtask

  task automatic test_cfg_coincident();
    int lat;
    // Neuron 0 is all-zero here; the coincident write turns it on.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_table = ONES; cfg_sel = SEL_ID;
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL coincident_err got %b want 0", cfg_err); end
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL coincident_lat got %0d want 4", lat); end
    checks++; if (out_data !== 4'b0011) begin errors++; $display("FAIL coincident_data got %b want 0011", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_data = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready c=%0d got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid c=%0d got %b want 0", c, out_valid); end
      checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL rstmid_data c=%0d got %b want 0000", c, out_data); end
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready got %b want 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_abandon c=%0d got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_bad_addr();
    int lat;
    b_cfg_sel = SEL_ID;
    b_cfg_we = 1'b1;
    b_cfg_addr = 2'd0; b_cfg_table = ONES; tick();
    b_cfg_addr = 2'd1; b_cfg_table = ZERO; tick();
    b_cfg_addr = 2'd2; b_cfg_table = ONES; tick();
    checks++; if (b_cfg_err !== 1'b0) begin errors++; $display("FAIL badaddr_valid_err got %b want 0", b_cfg_err); end
    b_cfg_addr = 2'd3; b_cfg_table = ZERO; tick();
    b_cfg_we = 1'b0;
    checks++; if (b_cfg_err !== 1'b1) begin errors++; $display("FAIL badaddr_err got %b want 1", b_cfg_err); end
    tick();
    checks++; if (b_cfg_err !== 1'b0) begin errors++; $display("FAIL badaddr_err_pulse got %b want 0", b_cfg_err); end
    b_in_data = 8'h00; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL badaddr_lat got %0d want 3", lat); end
    checks++; if (b_out_data !== 3'b101) begin errors++; $display("FAIL badaddr_data got %b want 101", b_out_data); end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_neuron();
    test_select();
    test_stall();
    test_cfg_during_eval();
    test_cfg_coincident();
    test_reset_mid();
    test_bad_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
